// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, sequencer states and instruction field positions
package alu_pkg;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SLT = 3'b100;
    localparam logic [2:0] LI  = 3'b101;
    localparam logic [2:0] NOP = 3'b110;
    localparam logic [2:0] ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } seq_state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RB_MSB  = 10;
    localparam int RB_LSB  = 9;
    localparam int RC_MSB  = 8;
    localparam int RC_LSB  = 7;
    localparam int IMM_MSB = 10;
    localparam int IMM_LSB = 3;

    function automatic logic op_writes(input logic [2:0] op);
        return (op <= LI);
    endfunction

    // Only the true ALU operations reach the ALU; LI/NOP/illegal park it on ADD.
    function automatic logic [2:0] alu_sel(input logic [2:0] op);
        return (op <= SLT) ? op : ADD;
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// rtl/regfile4x8.sv - 4x8 register file, two combinational reads, one synchronous write
module regfile4x8
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rd_addr_a,
    output logic [7:0] rd_data_a,
    input  logic [1:0] rd_addr_b,
    output logic [7:0] rd_data_b,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data
);

    logic [7:0] regs [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state control sequencer for the 8-bit ALU; ALU_SEQ_ZERO_FLAG_EN adds zero output
module alu_sequencer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_c,
    input  logic [7:0]  alu_res,
    output logic        done,
    output logic [7:0]  result,
    output logic        illegal
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [15:3] instr_q;
    logic        accept;
    logic [7:0]  rb_data;
    logic [7:0]  rc_data;
    logic [7:0]  wb_value;
    logic        wr_en;

    logic [2:0]  op_q;
    logic [1:0]  rd_q;
    logic [1:0]  rb_q;
    logic [1:0]  rc_q;
    logic [7:0]  imm_q;

    assign op_q  = instr_q[OP_MSB:OP_LSB];
    assign rd_q  = instr_q[RD_MSB:RD_LSB];
    assign rb_q  = instr_q[RB_MSB:RB_LSB];
    assign rc_q  = instr_q[RC_MSB:RC_LSB];
    assign imm_q = instr_q[IMM_MSB:IMM_LSB];

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is gated by rst_n so it is low throughout reset, not just after the first edge.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = rst_n;
                if (instr_valid && rst_n) begin
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_value = 8'h00;
        if (op_q == LI) begin
            wb_value = imm_q;
        end else if (op_writes(op_q)) begin
            wb_value = alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
            alu_op  <= ADD;
            alu_b   <= 8'h00;
            alu_c   <= 8'h00;
            done    <= 1'b0;
            illegal <= 1'b0;
            result  <= 8'h00;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero    <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            if (accept) begin
                instr_q <= instr[15:3];
            end
            case (state_q)
                DECODE: begin
                    alu_op <= alu_sel(op_q);
                    alu_b  <= rb_data;
                    alu_c  <= rc_data;
                end
                // Results land on the EXEC->WB edge so done/result are visible during WB.
                EXEC: begin
                    done    <= 1'b1;
                    illegal <= (op_q == ILL);
                    result  <= wb_value;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    if (op_writes(op_q)) begin
                        zero <= (wb_value == 8'h00);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign wr_en = (state_q == WB) && op_writes(op_q);

    regfile4x8 u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rb_q),
        .rd_data_a (rb_data),
        .rd_addr_b (rc_q),
        .rd_data_b (rc_data),
        .wr_en     (wr_en),
        .wr_addr   (rd_q),
        .wr_data   (result)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer against a register-file model
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [7:0]  alu_b;
    logic [7:0]  alu_c;
    logic [7:0]  alu_res;
    logic        done;
    logic [7:0]  result;
    logic        illegal;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        zero;
    logic        mzero;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] mregs [4];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_res     (alu_res),
        .done        (done),
        .result      (result),
        .illegal     (illegal)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .zero        (zero)
`endif
    );

    // The external combinational ALU the sequencer drives.
    always_comb begin
        case (alu_op)
            3'b000:  alu_res = alu_b + alu_c;
            3'b001:  alu_res = alu_b - alu_c;
            3'b010:  alu_res = alu_b & alu_c;
            3'b011:  alu_res = alu_b | alu_c;
            3'b100:  alu_res = (alu_b < alu_c) ? 8'h01 : 8'h00;
            default: alu_res = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rb, input int rc);
        logic [6:0] junk;
        junk = 7'($urandom);
        return {3'(op), 2'(rd), 2'(rb), 2'(rc), junk};
    endfunction

    function automatic logic [15:0] enc_li(input int rd, input int imm);
        logic [2:0] junk;
        junk = 3'($urandom);
        return {3'b101, 2'(rd), 8'(imm), junk};
    endfunction

    // Reference: executes one instruction on the model register file.
    task automatic model_exec(input logic [15:0] ins, output logic [7:0] res, output logic ill);
        int op;
        logic [7:0] b, c;
        op  = int'(ins[15:13]);
        b   = mregs[ins[10:9]];
        c   = mregs[ins[8:7]];
        ill = (op == 7);
        case (op)
            0: res = b + c;
            1: res = b - c;
            2: res = b & c;
            3: res = b | c;
            4: res = (int'(b) < int'(c)) ? 8'h01 : 8'h00;
            5: res = ins[10:3];
            default: res = 8'h00;
        endcase
        if (op <= 5) begin
            mregs[ins[12:11]] = res;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            mzero = (res == 8'h00);
`endif
        end
    endtask

    task automatic run(input logic [15:0] ins, input string tag);
        logic [7:0] exp_b, exp_c, exp_res;
        logic [2:0] exp_op;
        logic exp_ill;
        int waitc;
        exp_b  = mregs[ins[10:9]];
        exp_c  = mregs[ins[8:7]];
        exp_op = (ins[15:13] <= 3'd4) ? ins[15:13] : 3'd0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        waitc = 0;
        while (!instr_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (!instr_ready) begin
            check({tag, "/accept_timeout"}, 0, 1);
            instr_valid = 1'b0;
            return;
        end
        model_exec(ins, exp_res, exp_ill);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        check({tag, "/decode_ready"}, instr_ready, 0);
        check({tag, "/decode_done"}, done, 0);
        @(negedge clk);
        check({tag, "/exec_op"}, alu_op, exp_op);
        check({tag, "/exec_b"}, alu_b, exp_b);
        check({tag, "/exec_c"}, alu_c, exp_c);
        check({tag, "/exec_done"}, done, 0);
        @(negedge clk);
        check({tag, "/wb_done"}, done, 1);
        check({tag, "/wb_result"}, result, exp_res);
        check({tag, "/wb_illegal"}, illegal, exp_ill);
        check({tag, "/wb_ready"}, instr_ready, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check({tag, "/wb_zero"}, zero, mzero);
`endif
        @(negedge clk);
        check({tag, "/idle_done"}, done, 0);
        check({tag, "/idle_illegal"}, illegal, 0);
        check({tag, "/idle_ready"}, instr_ready, 1);
        check({tag, "/idle_result_hold"}, result, exp_res);
        check({tag, "/idle_b_hold"}, alu_b, exp_b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready"}, instr_ready, 0);
        check({tag, "/alu_op"}, alu_op, 0);
        check({tag, "/alu_b"}, alu_b, 0);
        check({tag, "/alu_c"}, alu_c, 0);
        check({tag, "/done"}, done, 0);
        check({tag, "/result"}, result, 0);
        check({tag, "/illegal"}, illegal, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        mzero = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_cyc [$];
        logic [7:0] hv_res [$];
        logic [7:0] r;
        logic il;
        int hv_idx;

        clear_model();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("reset/ready_after_release", instr_ready, 1);

        // LI/LI/ADD wrap
        run(enc_li(1, 8'hF0), "li_r1");
        run(enc_li(2, 8'h20), "li_r2");
        run(enc(0, 3, 1, 2), "add_wrap");
        check("add_wrap/const", result, 8'h10);

        // SUB wrap and unsigned SLT
        run(enc_li(1, 8'h05), "li_r1b");
        run(enc_li(2, 8'h07), "li_r2b");
        run(enc(1, 0, 1, 2), "sub_wrap");
        check("sub_wrap/const", result, 8'hFE);
        run(enc(4, 3, 1, 2), "slt_true");
        check("slt_true/const", result, 8'h01);
        run(enc_li(1, 8'h80), "li_r1c");
        run(enc_li(2, 8'h01), "li_r2c");
        run(enc(4, 3, 1, 2), "slt_unsigned");
        check("slt_unsigned/const", result, 8'h00);

        // Illegal does not write r2
        run(enc(7, 2, 1, 1), "illegal");
        check("illegal/const_flag", illegal, 0);
        run(enc(3, 2, 2, 2), "or_after_ill");
        check("or_after_ill/const", result, 8'h01);

        // instr_valid held high for 8 cycles with changing instr
        @(negedge clk);
        instr_valid = 1'b1;
        hv_idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            instr = ($urandom_range(0, 3) == 0) ? enc_li($urandom_range(0, 3), $urandom_range(0, 255))
                                                 : enc($urandom_range(0, 7), $urandom_range(0, 3),
                                                       $urandom_range(0, 3), $urandom_range(0, 3));
            check("hold/ready", instr_ready, (cyc % 4) == 0);
            if (instr_ready) begin
                acc_cyc.push_back(cyc);
                model_exec(instr, r, il);
                hv_res.push_back(r);
            end
            if ((cyc % 4) == 3) begin
                check("hold/done", done, 1);
                if (hv_idx < hv_res.size()) check("hold/result", result, hv_res[hv_idx]);
                hv_idx++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("hold/accept_count", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("hold/spacing", acc_cyc[1] - acc_cyc[0], 4);

        // Reset during EXEC of an ADD
        run(enc_li(1, 8'h11), "pre_rst_li");
        @(negedge clk);
        instr = enc(0, 3, 1, 1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        clear_model();
        rst_n = 1'b1;
        #1;
        check("mid_rst/ready_release", instr_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst/no_done", done, 0);
        end
        run(enc(3, 0, 0, 1), "rst_read01");
        check("rst_read01/const", result, 8'h00);
        run(enc(3, 1, 2, 3), "rst_read23");
        check("rst_read23/const", result, 8'h00);

`ifdef ALU_SEQ_ZERO_FLAG_EN
        run(enc_li(1, 8'h80), "z_li");
        run(enc(0, 2, 1, 1), "z_add");
        check("z_add/const", zero, 1);
        run(enc(6, 0, 0, 0), "z_nop");
        check("z_nop/const", zero, 1);
        run(enc_li(3, 8'h01), "z_li1");
        check("z_li1/const", zero, 0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                run(enc_li($urandom_range(0, 3), $urandom_range(0, 255)), "rand_li");
            else
                run(enc($urandom_range(0, 7), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer that drives the 8-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes them. It reads operands from an internal 4x8 register file, presents `alu_op`/operands to the ALU, captures `alu_out`, and writes the result back. The ALU stays purely combinational; this block owns all state and ordering.

## Interface
- `ZERO_FLAG` – no parameter; the only option is the macro in Configuration.
- `clk` in 1 – single clock; all state updates on rising edge.
- `rst_n` in 1 – synchronous, active-low reset.
- `instr_valid` in 1 – instruction offered.
- `instr_ready` out 1 – block can accept an instruction.
- `instr` in 16 – `[15:13]` op, `[12:11]` rd, `[10:9]` rb, `[8:7]` rc; for LI the 8-bit immediate is `[10:3]`.
- `alu_op` out 3 – ALU operation select.
- `alu_b` out 8 – ALU operand b.
- `alu_c` out 8 – ALU operand c.
- `alu_res` in 8 – ALU result, combinational from the three outputs above.
- `done` out 1 – one-cycle completion pulse.
- `result` out 8 – value written, or would-be value; held until next `done`.
- `illegal` out 1 – qualifies `done`; opcode was 111.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LI, 110 NOP, 111 illegal.
- States: IDLE → DECODE → EXEC → WB → IDLE. There are no other transitions except reset.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, the instruction is latched and the FSM goes to DECODE. The instruction is not latched when `instr_valid`=0.
- DECODE: reads `rb` and `rc` and registers them into `alu_b`/`alu_c`. Registers `alu_op` = op[2:0] for ops 000–100, otherwise 000.
- EXEC: outputs held stable. `alu_res` is sampled at the end of EXEC. LI takes the immediate instead of `alu_res`.
- WB: writes `rd` for ADD/SUB/AND/OR/SLT/LI. NOP and illegal do not write. `done`=1 and `result` updates.
  - NOP `result` = 0.
  - Illegal: `result` = 0 and `illegal`=1.
- All arithmetic is 8-bit and wraps modulo 256. SLT is unsigned and writes 0x01 or 0x00.
- r0 is an ordinary writable register. All four registers are reset to 0x00.
- rb, rc and rd may alias. A read in DECODE always sees the prior instruction's WB because instructions never overlap.
- `instr_valid` held high while busy: not accepted; `instr` may change freely.
- Reset mid-operation: FSM returns to IDLE, the in-flight instruction is dropped with no write and no `done`, and the register file is cleared.
- Reset values:
  - `instr_ready` 0 while `rst_n`=0, 1 in the first cycle after release.
  - `alu_op` 000, `alu_b` 0x00, `alu_c` 0x00.
  - `done` 0, `result` 0x00, `illegal` 0.

## Timing
- Accept on edge N. DECODE in cycle N+1, EXEC in N+2, WB in N+3 with `done`=1. `instr_ready` is 1 again in N+4.
- Throughput is one instruction per 4 cycles. Back-to-back acceptance is possible in the first IDLE cycle.
- `alu_op`, `alu_b` and `alu_c` are registered and change only at the DECODE→EXEC boundary. They hold through WB and IDLE.
- `done` and `illegal` are high for exactly one cycle. `result` persists.

## Configuration
- `ALU_SEQ_ZERO_FLAG_EN` defined: adds output `zero` (1 bit). It is registered in WB as (`result`==0x00) for writing ops, left unchanged for NOP and illegal, and reset to 0.
- `ALU_SEQ_ZERO_FLAG_EN` undefined: port and logic are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams ADD/SUB/AND/OR/SLT/LI/NOP/ILL, which are the same encodings the ALU uses;
  - the state enum IDLE/DECODE/EXEC/WB;
  - the instruction field bit positions.
- Sub-module `regfile4x8`: two combinational read ports and one synchronous write port with write enable. It is cleared by the synchronous active-low reset.

## Test plan
- LI r1←0xF0, LI r2←0x20, ADD r3=r1+r2 → `result`=0x10, `done` 3 cycles after accept, `illegal`=0.
- LI r1←0x05, LI r2←0x07, SUB r0=r1-r2 → 0xFE. Then SLT r3=r1,r2 → 0x01. SLT with 0x80,0x01 → 0x00 (unsigned).
- Illegal op 111 with rd=r2 → `done`=1, `illegal`=1, `result`=0x00; r2 unchanged, checked by a following OR r2,r2.
- `instr_valid` held high across 8 cycles with changing `instr` → exactly 2 accepts at 4-cycle spacing; `instr_ready` low in DECODE/EXEC/WB.
- Reset asserted during EXEC of ADD → no `done`; all outputs at reset values the next cycle; `instr_ready`=1 after release; registers read 0x00.
- Macro defined: ADD giving 0x00 → `zero`=1. A following NOP leaves `zero`=1. LI 0x01 → `zero`=0.
